// File: rtl/dilithium_pkg.sv
// -----------------------------------------------------------------------------
// dilithium_pkg
// Shared constants and encodings for the Dilithium polynomial-vector datapath.
//   N        : coefficients per polynomial
//   Q        : Dilithium modulus
//   COEFF_W  : signed coefficient storage width
//   mode_e   : transform direction driven to the shared NTT core
//   seq_state_e : polyvec sequencer state encoding
// -----------------------------------------------------------------------------
package dilithium_pkg;

    localparam int N       = 256;
    localparam int Q       = 8380417;
    localparam int COEFF_W = 32;

    typedef enum logic {
        MODE_NTT    = 1'b0,
        MODE_INVNTT = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_e;

endpackage

// File: rtl/polyvec_transform_seq_if.sv
// -----------------------------------------------------------------------------
// polyvec_transform_seq_if
// Start/done port pair between the polyvec sequencer and the shared transform
// core.
//   core_mode  : transform direction (0 = NTT, 1 = inverse NTT to Montgomery)
//   core_start : core request, held while the core works
//   core_inp   : operand polynomial, N coefficients of COEFF_W bits
//   core_out   : result polynomial, same layout
//   core_done  : core completion, result valid while high
// master = sequencer side, slave = core side.
// -----------------------------------------------------------------------------
interface polyvec_transform_seq_if
    import dilithium_pkg::*;
#(
    parameter int N       = dilithium_pkg::N,
    parameter int COEFF_W = dilithium_pkg::COEFF_W
);

    logic                   core_mode;
    logic                   core_start;
    logic [N*COEFF_W-1:0]   core_inp;
    logic [N*COEFF_W-1:0]   core_out;
    logic                   core_done;

    modport master (
        output core_mode,
        output core_start,
        output core_inp,
        input  core_out,
        input  core_done
    );

    modport slave (
        input  core_mode,
        input  core_start,
        input  core_inp,
        output core_out,
        output core_done
    );

endinterface

// File: rtl/polyvec_seq_ctrl.sv
// -----------------------------------------------------------------------------
// polyvec_seq_ctrl
// Sequencer FSM (IDLE -> LOAD -> RUN -> ... -> FINISH) plus the polynomial
// index and vector-length counters.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   start        : run request, honoured only in IDLE
//   mode         : direction, latched on an accepted start
//   vec_len      : requested vector length, clamped to MAX_K and latched
//   core_done    : completion from the shared core
//   busy, done   : status, done is a single-cycle pulse in FINISH
//   core_start   : core request (RUN and core not yet done)
//   core_mode    : latched direction
//   cur_idx      : polynomial currently in the core, doubles as slot select
//   load_en      : capture slot[cur_idx] of the input vector into the operand
//   wr_en        : write core result into output slot[cur_idx]
// -----------------------------------------------------------------------------
module polyvec_seq_ctrl
    import dilithium_pkg::*;
#(
    parameter int MAX_K = 8,
    parameter int IDX_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [IDX_W-1:0] vec_len,
    input  logic             core_done,
    output logic             busy,
    output logic             done,
    output logic             core_start,
    output logic             core_mode,
    output logic [IDX_W-1:0] cur_idx,
    output logic             load_en,
    output logic             wr_en
);

    seq_state_e       state_reg;
    seq_state_e       state_next;
    logic [IDX_W-1:0] len_reg;
    logic [IDX_W-1:0] cur_idx_reg;
    mode_e            mode_reg;

    logic [IDX_W-1:0] len_clamped;
    logic [IDX_W:0]   idx_inc;
    logic             accept;

    // Oversized requests are processed as a full MAX_K vector.
    assign len_clamped = (vec_len > IDX_W'(MAX_K)) ? IDX_W'(MAX_K) : vec_len;
    // One extra bit so cur_idx + 1 never wraps before the compare.
    assign idx_inc     = {1'b0, cur_idx_reg} + 1'b1;
    assign accept      = (state_reg == ST_IDLE) && start;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (len_clamped != '0) ? ST_LOAD : ST_FINISH;
                end
            end
            ST_LOAD: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (core_done) begin
                    state_next = (idx_inc < {1'b0, len_reg}) ? ST_LOAD : ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy       = (state_reg != ST_IDLE);
        done       = (state_reg == ST_FINISH);
        load_en    = (state_reg == ST_LOAD);
        // Dropping the request in the done cycle guarantees a low gap
        // (the following LOAD) before the next polynomial.
        core_start = (state_reg == ST_RUN) && !core_done;
        wr_en      = (state_reg == ST_RUN) && core_done;
    end

    // Run parameters and polynomial index. cur_idx is left at len_q after
    // the run so the caller can read how many slots were processed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len_reg     <= '0;
            cur_idx_reg <= '0;
            mode_reg    <= MODE_NTT;
        end else if (accept) begin
            len_reg     <= len_clamped;
            cur_idx_reg <= '0;
            mode_reg    <= mode_e'(mode);
        end else if (wr_en) begin
            cur_idx_reg <= idx_inc[IDX_W-1:0];
        end
    end

    assign cur_idx   = cur_idx_reg;
    assign core_mode = mode_reg;

endmodule

// File: rtl/polyvec_transform_seq.sv
// -----------------------------------------------------------------------------
// polyvec_transform_seq
// Runs one external polynomial transform core (forward NTT or inverse NTT to
// Montgomery) over a vector of up to MAX_K polynomials. Coefficients pass
// through bit-exact; this block only sequences and stores.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   start        : run request, sampled only when idle
//   mode         : 0 = NTT, 1 = inverse NTT, latched on accepted start
//   vec_len      : polynomials to process (clamped to MAX_K)
//   v_in         : input vector, slot x at bits [P*x +: P], P = N*COEFF_W
//   v_out        : registered result vector, same layout
//   busy, done   : status and single-cycle completion pulse
//   cur_idx      : polynomial currently in the core
//   core         : master side of the start/done port pair to the core
// -----------------------------------------------------------------------------
module polyvec_transform_seq
    import dilithium_pkg::*;
#(
    parameter int MAX_K   = 8,
    parameter int N       = dilithium_pkg::N,
    parameter int COEFF_W = dilithium_pkg::COEFF_W,
    parameter int IDX_W   = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         mode,
    input  logic [IDX_W-1:0]             vec_len,
    input  logic [MAX_K*N*COEFF_W-1:0]   v_in,
    output logic [MAX_K*N*COEFF_W-1:0]   v_out,
    output logic                         busy,
    output logic                         done,
    output logic [IDX_W-1:0]             cur_idx,
    polyvec_transform_seq_if.master      core
);

    localparam int P     = N * COEFF_W;
    localparam int SEL_W = (MAX_K > 1) ? $clog2(MAX_K) : 1;

    logic             load_en;
    logic             wr_en;
    logic             core_start_int;
    logic             core_mode_int;
    logic [IDX_W-1:0] cur_idx_int;
    logic [SEL_W-1:0] slot_sel;
    logic [P-1:0]     in_slot [MAX_K];
    logic [P-1:0]     core_inp_reg;

    polyvec_seq_ctrl #(
        .MAX_K (MAX_K),
        .IDX_W (IDX_W)
    ) u_ctrl (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .vec_len    (vec_len),
        .core_done  (core.core_done),
        .busy       (busy),
        .done       (done),
        .core_start (core_start_int),
        .core_mode  (core_mode_int),
        .cur_idx    (cur_idx_int),
        .load_en    (load_en),
        .wr_en      (wr_en)
    );

    // cur_idx is always below MAX_K whenever the select is used (LOAD).
    assign slot_sel = cur_idx_int[SEL_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < MAX_K; gi++) begin : g_in_slot
            assign in_slot[gi] = v_in[gi*P +: P];
        end
    endgenerate

    // Operand register: v_in is sampled once per polynomial, in LOAD.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            core_inp_reg <= '0;
        end else if (load_en) begin
            core_inp_reg <= in_slot[slot_sel];
        end
    end

    // Result slots: only the slot being finished is written, so slots past
    // the run length keep whatever they held before.
    generate
        for (gi = 0; gi < MAX_K; gi++) begin : g_out_slot
            logic [P-1:0] slot_reg;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    slot_reg <= '0;
                end else if (wr_en && (cur_idx_int == IDX_W'(gi))) begin
                    slot_reg <= core.core_out;
                end
            end

            assign v_out[gi*P +: P] = slot_reg;
        end
    endgenerate

    assign core.core_start = core_start_int;
    assign core.core_mode  = core_mode_int;
    assign core.core_inp   = core_inp_reg;
    assign cur_idx         = cur_idx_int;

endmodule
